seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the stopwatch display driver: samples the multiplexed seven-segment bus (`seg`/`an`) and reconstructs the four displayed hex digits. Used on-chip for display self-check and in benches as a scoreboard front end. It emits a one-cycle `frame_valid` strobe each time all four digit positions have been captured, and flags blanked digits and illegal segment patterns.

---
 rtl/seg7_scan_decoder_if.sv | 11 +
 rtl/seg7_scan_decoder.sv | 158 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed seven-segment display bus (one digit lit at a time).
// Not a valid/ready handshake: the driver (master) owns seg/an and changes
// them freely; the decoder (slave) only observes, and a value counts once it
// has held steady long enough to be treated as a settled digit.
interface seg7_scan_decoder_if;
  logic [6:0] seg;  // active-low segments, seg[0]=a .. seg[6]=g
  logic [3:0] an;   // active-low anode selects, an[0] = rightmost digit

  modport master (output seg, output an);
  modport slave  (input seg, input an);
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed seven-segment bus and rebuilds the
// four displayed hex digits, flagging blanked and non-hex patterns, pulsing
// frame_valid once all four positions have been captured.
// Optional feature macro: SEG7_DEC_TIMEOUT_EN (builds the no-activity timeout
// and display_lost; without it display_lost is tied to 0).
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_scan_decoder_if.slave   bus,
  output logic [15:0]          digits,
  output logic [3:0]           blank,
  output logic [3:0]           bad_pat,
  output logic                 frame_valid,
  output logic                 display_lost
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [10:0]   s;          // last sampled {an,seg}
  logic [SW-1:0] stab_cnt;   // edges the current value has repeated
  logic          armed;      // one acceptance per stable run
  logic [3:0]    seen;       // positions captured in the current frame

  logic [10:0]   sample;
  logic          same;
  logic          run_done;
  logic          one_low;
  logic [1:0]    sel;
  logic [3:0]    sel_mask;
  logic          accept;
  logic          to_hit;
  logic [4:0]    dec;

  // seg pattern -> {table hit, hex value}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = {1'b1, 4'h0};
      7'h79:   decode = {1'b1, 4'h1};
      7'h24:   decode = {1'b1, 4'h2};
      7'h30:   decode = {1'b1, 4'h3};
      7'h19:   decode = {1'b1, 4'h4};
      7'h12:   decode = {1'b1, 4'h5};
      7'h02:   decode = {1'b1, 4'h6};
      7'h78:   decode = {1'b1, 4'h7};
      7'h00:   decode = {1'b1, 4'h8};
      7'h10:   decode = {1'b1, 4'h9};
      7'h08:   decode = {1'b1, 4'hA};
      7'h03:   decode = {1'b1, 4'hB};
      7'h46:   decode = {1'b1, 4'hC};
      7'h21:   decode = {1'b1, 4'hD};
      7'h06:   decode = {1'b1, 4'hE};
      7'h0E:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // Run detection and acceptance: the run is accepted on the edge where the
  // repeat counter would reach STABLE_CYCLES-1; decode always uses s.
  always_comb begin
    sample   = {bus.an, bus.seg};
    same     = (s == sample);
    run_done = armed && same && (stab_cnt == SW'(STABLE_CYCLES - 2));
    one_low  = 1'b1;
    sel      = 2'd0;
    case (s[10:7])
      4'b1110: sel = 2'd0;
      4'b1101: sel = 2'd1;
      4'b1011: sel = 2'd2;
      4'b0111: sel = 2'd3;
      default: one_low = 1'b0;
    endcase
    sel_mask = 4'b0001 << sel;
    accept   = run_done && one_low;
    dec      = decode(s[6:0]);
  end

  // Sampling register, saturating stability counter and arm flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '1;
      stab_cnt <= '0;
      armed    <= 1'b1;
    end else begin
      s <= sample;
      if (!same) begin
        stab_cnt <= '0;
        armed    <= 1'b1;
      end else begin
        if (stab_cnt != SW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + SW'(1);
        if (run_done) armed <= 1'b0;
      end
    end
  end

  // Digit capture, flags, seen mask and frame completion strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= 16'h0000;
      blank       <= 4'hF;
      bad_pat     <= 4'h0;
      frame_valid <= 1'b0;
      seen        <= 4'h0;
    end else begin
      frame_valid <= 1'b0;
      if (accept) begin
        if (dec[4]) begin
          digits[sel*4 +: 4] <= dec[3:0];
          blank[sel]         <= 1'b0;
          bad_pat[sel]       <= 1'b0;
        end else if (s[6:0] == 7'h7F) begin
          digits[sel*4 +: 4] <= 4'h0;
          blank[sel]         <= 1'b1;
          bad_pat[sel]       <= 1'b0;
        end else begin
          digits[sel*4 +: 4] <= 4'h0;
          blank[sel]         <= 1'b0;
          bad_pat[sel]       <= 1'b1;
        end
        if ((seen | sel_mask) == 4'hF) begin
          frame_valid <= 1'b1;
          seen        <= 4'h0;
        end else begin
          seen <= seen | sel_mask;
        end
      end else if (to_hit) begin
        seen <= 4'h0;
      end
    end
  end

`ifdef SEG7_DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = !accept && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Edges since last acceptance; acceptance beats a same-edge timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt       <= '0;
      display_lost <= 1'b0;
    end else if (accept) begin
      to_cnt       <= '0;
      display_lost <= 1'b0;
    end else begin
      if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);
      if (to_hit) display_lost <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign display_lost = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Inputs change 1 time unit after a rising edge, so they are settled before
// the next edge; outputs are read at that same point.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  bad_pat;
  logic        frame_valid;
  logic        display_lost;

  int errors = 0;
  int checks = 0;

  seg7_scan_decoder_if bus_if ();

  seg7_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .digits      (digits),
    .blank       (blank),
    .bad_pat     (bad_pat),
    .frame_valid (frame_valid),
    .display_lost(display_lost)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [3:0] scan_an [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] scan_seg[4] = '{7'h79, 7'h24, 7'h30, 7'h19};

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] sg);
    bus_if.an  = a;
    bus_if.seg = sg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_d;
    logic [3:0]  exp_b;
    drive(4'hE, 7'h24);
    rst = 1'b1;
    tick();
    tick();
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (blank !== 4'hF) begin errors++; $display("FAIL reset_blank got=%h exp=f", blank); end
    checks++; if (bad_pat !== 4'h0) begin errors++; $display("FAIL reset_bad got=%h exp=0", bad_pat); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (display_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got=%b exp=0", display_lost); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_d = (k >= 3) ? 16'h0002 : 16'h0000;
      exp_b = (k >= 3) ? 4'hE : 4'hF;
      checks++; if (digits !== exp_d) begin errors++; $display("FAIL post_reset_digits edge=%0d got=%h exp=%h", k, digits, exp_d); end
      checks++; if (blank !== exp_b) begin errors++; $display("FAIL post_reset_blank edge=%0d got=%h exp=%h", k, blank, exp_b); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL post_reset_fv edge=%0d got=%b exp=0", k, frame_valid); end
    end
  endtask

  task automatic test_full_scan();
    logic exp_fv;
    do_reset();
    for (int slot = 0; slot < 4; slot++) begin
      drive(scan_an[slot], scan_seg[slot]);
      for (int k = 0; k < 8; k++) begin
        tick();
        exp_fv = (slot == 3) && (k == 3);
        checks++; if (frame_valid !== exp_fv) begin errors++; $display("FAIL scan_fv slot=%0d edge=%0d got=%b exp=%b", slot, k, frame_valid, exp_fv); end
      end
    end
    checks++; if (digits !== 16'h4321) begin errors++; $display("FAIL scan_digits got=%h exp=4321", digits); end
    checks++; if (blank !== 4'h0) begin errors++; $display("FAIL scan_blank got=%h exp=0", blank); end
    checks++; if (bad_pat !== 4'h0) begin errors++; $display("FAIL scan_bad got=%h exp=0", bad_pat); end
  endtask

  // continues from the full-scan state (4321, nothing blank)
  task automatic test_blank_bad();
    drive(4'hD, 7'h7F);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL blank_fv edge=%0d got=%b exp=0", k, frame_valid); end
    end
    checks++; if (digits !== 16'h4301) begin errors++; $display("FAIL blank_digits got=%h exp=4301", digits); end
    checks++; if (blank !== 4'b0010) begin errors++; $display("FAIL blank_mask got=%b exp=0010", blank); end
    drive(4'hB, 7'h55);
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL bad_fv edge=%0d got=%b exp=0", k, frame_valid); end
    end
    checks++; if (digits !== 16'h4001) begin errors++; $display("FAIL bad_digits got=%h exp=4001", digits); end
    checks++; if (blank !== 4'b0010) begin errors++; $display("FAIL bad_blank got=%b exp=0010", blank); end
    checks++; if (bad_pat !== 4'b0100) begin errors++; $display("FAIL bad_mask got=%b exp=0100", bad_pat); end
  endtask

  task automatic test_illegal_anode();
    drive(4'hC, 7'h79);
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if (digits !== 16'h4001) begin errors++; $display("FAIL illegal_digits edge=%0d got=%h exp=4001", k, digits); end
      checks++; if ({blank, bad_pat} !== 8'h24) begin errors++; $display("FAIL illegal_flags edge=%0d got=%h exp=24", k, {blank, bad_pat}); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL illegal_fv edge=%0d got=%b exp=0", k, frame_valid); end
    end
  endtask

  task automatic test_glitch();
    logic [15:0] exp_d;
    logic [3:0]  exp_b;
    do_reset();
    drive(4'hE, 7'h40);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({digits, blank} !== 20'h0000F) begin errors++; $display("FAIL glitch_short edge=%0d got=%h exp=0000f", k, {digits, blank}); end
    end
    drive(4'hE, 7'h79);
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_d = (k >= 3) ? 16'h0001 : 16'h0000;
      exp_b = (k >= 3) ? 4'hE : 4'hF;
      checks++; if ({digits, blank} !== {exp_d, exp_b}) begin errors++; $display("FAIL glitch_long edge=%0d got=%h exp=%h", k, {digits, blank}, {exp_d, exp_b}); end
    end
  endtask

  task automatic test_timeout();
    logic exp_lost;
    logic exp_fv;
    do_reset();
    drive(4'hE, 7'h79);
    for (int k = 0; k < 8; k++) tick();  // accepted 4 edges before the loop ends
    checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL to_first_digit got=%h exp=0001", digits); end
    drive(4'hF, 7'h7F);
    for (int j = 1; j <= 70; j++) begin
      tick();
`ifdef SEG7_DEC_TIMEOUT_EN
      exp_lost = (4 + j) >= 64;
`else
      exp_lost = 1'b0;
`endif
      checks++; if (display_lost !== exp_lost) begin errors++; $display("FAIL to_lost edges_since_accept=%0d got=%b exp=%b", 4 + j, display_lost, exp_lost); end
    end
    // positions 1..3; digit 0 was seen before the timeout
    for (int slot = 1; slot < 4; slot++) begin
      drive(scan_an[slot], scan_seg[slot]);
      for (int k = 0; k < 8; k++) begin
        tick();
`ifdef SEG7_DEC_TIMEOUT_EN
        exp_fv   = 1'b0;
        exp_lost = (slot == 1) && (k < 3);
`else
        exp_fv   = (slot == 3) && (k == 3);
        exp_lost = 1'b0;
`endif
        checks++; if (frame_valid !== exp_fv) begin errors++; $display("FAIL to_rescan_fv slot=%0d edge=%0d got=%b exp=%b", slot, k, frame_valid, exp_fv); end
        checks++; if (display_lost !== exp_lost) begin errors++; $display("FAIL to_rescan_lost slot=%0d edge=%0d got=%b exp=%b", slot, k, display_lost, exp_lost); end
      end
    end
    drive(4'hE, 7'h79);
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef SEG7_DEC_TIMEOUT_EN
      exp_fv = (k == 3);
`else
      exp_fv = 1'b0;
`endif
      checks++; if (frame_valid !== exp_fv) begin errors++; $display("FAIL to_final_fv edge=%0d got=%b exp=%b", k, frame_valid, exp_fv); end
    end
    checks++; if (digits !== 16'h4321) begin errors++; $display("FAIL to_digits got=%h exp=4321", digits); end
  endtask

  // sequence and final report
  initial begin
    drive(4'hF, 7'h7F);
    test_reset();
    test_full_scan();
    test_blank_bad();
    test_illegal_anode();
    test_glitch();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
